// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and sizing helpers.
// Optional build macro used by this slice: SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: one-bit full adder from two half-adder stages.
// Shared by the bit-serial datapath in serial_adder.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1 = a ^ b;
  assign hc1 = a & b;
  assign s   = hs1 ^ cin;
  assign hc2 = hs1 & cin;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the ovf_out signed-overflow port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign last    = (cnt == LAST);
  assign sum_cat = {fa_s, sum_sh};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, serial shift and result capture on the final bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_out  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_cat[WIDTH-1:1];
          carry  <= fa_co;
          if (last) begin
            sum_out  <= sum_cat;
            cout_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_out  <= carry ^ fa_co;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at WIDTH=8.
// Checks ovf_out as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_out;
`endif

  int n_chk;
  int n_fail;
  int lat;
  logic seen;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: in_valid must be known whenever it can be accepted.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && in_ready === 1'b1) begin
      n_chk++;
      assert (!$isunknown(in_valid)) else begin
        n_fail++;
        $error("FAIL in_valid_x: observed %b expected 0/1", in_valid);
      end
    end
  end

  // Called at the negedge after an acceptance edge.
  task automatic wait_valid(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 40) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo);
    int l;
    @(negedge clk);
    a_in = a; b_in = b; cin = c;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a_in = '1; b_in = '1; cin = 1'b1;
    chk({tag, "_busy"}, in_ready, 0);
    wait_valid(l);
    chk({tag, "_lat"}, l, W);
    chk({tag, "_sum"}, sum_out, es);
    chk({tag, "_cout"}, cout_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, ovf_out, eo);
`else
    if (eo === 1'bx) $display("note: unexpected x");
`endif
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ovdrop"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", cout_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf_out, 0);
`endif
    rst_n = 1'b1;

    do_op("t35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    do_op("tff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("t00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    do_op("t7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Backpressure with input noise while the result is held.
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_lat", lat, W);
    for (int i = 0; i < 5; i++) begin
      a_in = W'($urandom);
      in_valid = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum_out, 8'h30);
      chk("bp_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in = 8'hA0; b_in = 8'h0F; cin = 1'b0;
    chk("b2b_busy", in_ready, 0);
    wait_valid(lat);
    chk("b2b1_lat", lat, W);
    chk("b2b1_sum", sum_out, 8'h47);
    chk("b2b1_cout", cout_out, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_gap_ready", in_ready, 1);
    chk("b2b_gap_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b2_accepted", in_ready, 0);
    wait_valid(lat);
    chk("b2b2_lat", lat, W);
    chk("b2b2_sum", sum_out, 8'hAF);
    chk("b2b2_cout", cout_out, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b2_idle", in_ready, 1);

    // Reset in the middle of RUN.
    @(negedge clk);
    a_in = 8'h55; b_in = 8'h55; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum_out, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_result", seen, 0);
    do_op("post_abort", 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
